// File: rtl/cordic_pkg.sv
// Shared constants and elaboration-time helpers for the iterative CORDIC engine.
// Every fixed-point constant is built from real arithmetic and rounded to nearest.
package cordic_pkg;

  localparam logic [1:0] MODE_LIN  = 2'b00;
  localparam logic [1:0] MODE_CIRC = 2'b01;
  localparam logic [1:0] MODE_ILL  = 2'b10;
  localparam logic [1:0] MODE_HYP  = 2'b11;

  localparam int  SHIFT_W = 6;
  localparam int  TBL_N   = 64;
  localparam real PI_R    = 3.14159265358979323846;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  // Hyperbolic shifts executed twice so the series converges.
  function automatic logic hyp_repeat(input int s);
    return (s == 4) || (s == 13) || (s == 40);
  endfunction

  function automatic int cordic_iters(input int n, input logic [1:0] mode);
    int r;
    r = n;
    if (mode == MODE_HYP)
      for (int k = 1; k <= n; k++)
        if (hyp_repeat(k)) r++;
    return r;
  endfunction

  function automatic real sqrt_r(input real a);
    real r;
    r = (a > 1.0) ? a : 1.0;
    for (int i = 0; i < 60; i++) r = 0.5 * (r + a / r);
    return r;
  endfunction

  function automatic real atan_r(input int s);
    real x, x2, term, acc;
    if (s == 0) return PI_R / 4.0;
    x = 2.0 ** (0 - s);
    x2 = x * x;
    term = x;
    acc = 0.0;
    for (int k = 0; k < 40; k++) begin
      acc = acc + ((k % 2 == 1) ? -1.0 : 1.0) * term / real'(2 * k + 1);
      term = term * x2;
    end
    return acc;
  endfunction

  function automatic real atanh_r(input int s);
    real x, x2, term, acc;
    if (s == 0) return 0.0;
    x = 2.0 ** (0 - s);
    x2 = x * x;
    term = x;
    acc = 0.0;
    for (int k = 0; k < 40; k++) begin
      acc = acc + term / real'(2 * k + 1);
      term = term * x2;
    end
    return acc;
  endfunction

  function automatic real an_r(input int n);
    real p;
    p = 1.0;
    for (int i = 0; i < n; i++) p = p / (1.0 + 2.0 ** (0 - 2 * i));
    return sqrt_r(p);
  endfunction

  function automatic real inv_kh_r(input int n);
    real p;
    p = 1.0;
    for (int s = 1; s <= n; s++) begin
      p = p * (1.0 - 2.0 ** (0 - 2 * s));
      if (hyp_repeat(s)) p = p * (1.0 - 2.0 ** (0 - 2 * s));
    end
    return 1.0 / sqrt_r(p);
  endfunction

  function automatic longint to_fx(input real r, input int frac);
    return longint'(r * (2.0 ** frac));
  endfunction

endpackage

// File: rtl/cordic_microrotation.sv
// One combinational CORDIC step; i_neg selects d=-1, i_tbl is the angle/weight for this shift.
module cordic_microrotation
  import cordic_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic signed [BITS-1:0]    i_x,
  input  logic signed [BITS-1:0]    i_y,
  input  logic signed [BITS-1:0]    i_z,
  input  logic        [1:0]         i_mode,
  input  logic                      i_neg,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic signed [BITS-1:0]    i_tbl,
  output logic signed [BITS-1:0]    o_x,
  output logic signed [BITS-1:0]    o_y,
  output logic signed [BITS-1:0]    o_z
);

  logic signed [BITS-1:0] xs, ys;

  always_comb begin
    xs  = i_x >>> i_shift;
    ys  = i_y >>> i_shift;
    o_y = i_neg ? i_y - xs : i_y + xs;
    o_z = i_neg ? i_z + i_tbl : i_z - i_tbl;
    case (i_mode)
      MODE_CIRC: o_x = i_neg ? i_x + ys : i_x - ys;
      MODE_HYP:  o_x = i_neg ? i_x - ys : i_x + ys;
      default:   o_x = i_x;
    endcase
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative handshaked CORDIC: one micro-rotation reused per cycle under an IDLE/ITER/DONE FSM.
// Circular inputs are pre-rotated by pi so the full +/-pi range converges.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int N_ITERATION     = 16,
  parameter int INTEGER_BITS    = 3,
  parameter int FRACTIONAL_BITS = 29,
  parameter int BITS            = INTEGER_BITS + FRACTIONAL_BITS,
  parameter int TAG_BITS        = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic signed [BITS-1:0]    i_x,
  input  logic signed [BITS-1:0]    i_y,
  input  logic signed [BITS-1:0]    i_z,
  input  logic        [1:0]         i_mode,
  input  logic                      i_rot_en,
  input  logic        [TAG_BITS-1:0] i_tag,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [BITS-1:0]    o_x,
  output logic signed [BITS-1:0]    o_y,
  output logic signed [BITS-1:0]    o_z,
  output logic        [TAG_BITS-1:0] o_tag,
  output logic                      o_err
);

  localparam logic signed [BITS-1:0] AN_FX      = BITS'(to_fx(an_r(N_ITERATION), FRACTIONAL_BITS));
  localparam logic signed [BITS-1:0] INV_KH_FX  = BITS'(to_fx(inv_kh_r(N_ITERATION), FRACTIONAL_BITS));
  localparam logic signed [BITS-1:0] PI_FX      = BITS'(to_fx(PI_R, FRACTIONAL_BITS));
  localparam logic signed [BITS-1:0] HALF_PI_FX = BITS'(to_fx(PI_R / 2.0, FRACTIONAL_BITS));
  localparam logic [SHIFT_W-1:0] LAST_STD = SHIFT_W'(N_ITERATION - 1);
  localparam logic [SHIFT_W-1:0] LAST_HYP = SHIFT_W'(cordic_iters(N_ITERATION, MODE_HYP) - 1);

  logic signed [BITS-1:0] tbl_circ [TBL_N];
  logic signed [BITS-1:0] tbl_lin  [TBL_N];
  logic signed [BITS-1:0] tbl_hyp  [TBL_N];

  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    localparam longint AT  = to_fx(atan_r(g), FRACTIONAL_BITS);
    localparam longint LN  = to_fx(2.0 ** (0 - g), FRACTIONAL_BITS);
    localparam longint ATH = to_fx(atanh_r(g), FRACTIONAL_BITS);
    assign tbl_circ[g] = BITS'(AT);
    assign tbl_lin[g]  = BITS'(LN);
    assign tbl_hyp[g]  = BITS'(ATH);
  end

  state_e                 state_q, state_d;
  logic signed [BITS-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic [1:0]             mode_q, mode_d;
  logic                   rot_q, rot_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic                   err_q, err_d;
  logic [SHIFT_W-1:0]     cnt_q, cnt_d, shift_q, shift_d;
  logic                   rep_q, rep_d;
  logic                   rdy_q, rdy_d;

  logic signed [BITS-1:0] x0, y0, z0, xn, yn, zn, tbl;
  logic                   neg;

  always_comb begin
    x0 = i_x;
    y0 = i_y;
    z0 = i_z;
    case (i_mode)
      MODE_CIRC: begin
        if (i_rot_en) begin
          x0 = AN_FX;
          y0 = '0;
          if (i_z > HALF_PI_FX) begin
            z0 = i_z - PI_FX;
            x0 = -AN_FX;
          end else if (i_z < -HALF_PI_FX) begin
            z0 = i_z + PI_FX;
            x0 = -AN_FX;
          end
        end else begin
          z0 = '0;
          // Left half-plane: reflect through the origin and carry the pi offset in z.
          if (i_x[BITS-1]) begin
            x0 = -i_x;
            y0 = -i_y;
            z0 = i_y[BITS-1] ? -PI_FX : PI_FX;
          end
        end
      end
      MODE_LIN, MODE_HYP: begin
        if (i_rot_en) begin
          y0 = '0;
          if (i_mode == MODE_HYP) x0 = INV_KH_FX;
        end else begin
          z0 = '0;
        end
      end
      default: begin
        x0 = '0;
        y0 = '0;
        z0 = '0;
      end
    endcase
  end

  always_comb begin
    neg = rot_q ? z_q[BITS-1] : ~y_q[BITS-1];
    case (mode_q)
      MODE_CIRC: tbl = tbl_circ[shift_q];
      MODE_LIN:  tbl = tbl_lin[shift_q];
      default:   tbl = tbl_hyp[shift_q];
    endcase
  end

  cordic_microrotation #(.BITS(BITS)) u_step (
    .i_x     (x_q),
    .i_y     (y_q),
    .i_z     (z_q),
    .i_mode  (mode_q),
    .i_neg   (neg),
    .i_shift (shift_q),
    .i_tbl   (tbl),
    .o_x     (xn),
    .o_y     (yn),
    .o_z     (zn)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    rot_d   = rot_q;
    tag_d   = tag_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rep_d   = rep_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && rdy_q) begin
          x_d     = x0;
          y_d     = y0;
          z_d     = z0;
          mode_d  = i_mode;
          rot_d   = i_rot_en;
          tag_d   = i_tag;
          err_d   = (i_mode == MODE_ILL);
          cnt_d   = '0;
          shift_d = (i_mode == MODE_HYP) ? SHIFT_W'(1) : '0;
          rep_d   = 1'b0;
          state_d = (i_mode == MODE_ILL) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        x_d   = xn;
        y_d   = yn;
        z_d   = zn;
        cnt_d = cnt_q + SHIFT_W'(1);
        if (mode_q == MODE_HYP && hyp_repeat(int'(shift_q)) && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          shift_d = shift_q + SHIFT_W'(1);
          rep_d   = 1'b0;
        end
        if (cnt_q == ((mode_q == MODE_HYP) ? LAST_HYP : LAST_STD)) state_d = S_DONE;
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= '0;
      rot_q   <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      rep_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      rot_q   <= rot_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rep_q   <= rep_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_ready = rdy_q;
  assign o_valid = (state_q == S_DONE);
  assign o_x     = x_q;
  assign o_y     = y_q;
  assign o_z     = z_q;
  assign o_tag   = tag_q;
  assign o_err   = err_q && (state_q == S_DONE);

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Iterative, handshaked CORDIC engine: one micro-rotation datapath reused over N iterations, under an FSM.
- Supports circular, linear and hyperbolic modes, each in rotation or vectoring.
- Adds features the pipelined predecessor lacks:
  - circular quadrant pre-rotation (full ±pi range),
  - hyperbolic repeat iterations (k=4,13,40),
  - valid/ready flow control with tag pass-through,
  - illegal-mode error flag.
- Sits between the fixed-point math front-end and downstream consumers where area matters more than throughput.

Parameters:
- N_ITERATION, 16, base iteration count (1..40).
- INTEGER_BITS, 3, integer bits including sign; 3 covers ±pi.
- FRACTIONAL_BITS, 29, fractional bits.
- BITS, INTEGER_BITS+FRACTIONAL_BITS, datapath width.
- TAG_BITS, 4, width of the opaque tag returned with each result.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  input request.
- o_ready  out  1  engine can accept a request.
- i_x, i_y, i_z  in  BITS each  signed operands.
- i_mode  in  2  signed: -1 hyperbolic, 0 linear, +1 circular, -2 illegal.
- i_rot_en  in  1  1 selects rotation, 0 selects vectoring.
- i_tag  in  TAG_BITS  user tag.
- o_valid  out  1  result available.
- i_ready  in  1  downstream accepts the result.
- o_x, o_y, o_z  out  BITS each  signed results.
- o_tag  out  TAG_BITS  tag of the result.
- o_err  out  1  result came from an illegal mode; data outputs are zero.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - state becomes IDLE; all outputs, datapath registers and the counter go to 0; o_ready=0.
  - o_ready=1 in the first cycle after release.
  - Reset mid-operation aborts silently and produces no result.
- FSM states are IDLE, ITER and DONE.
  - IDLE: o_ready=1. On i_valid&&o_ready:
    - load the pre-rotated operands, tag and mode;
    - clear the counter;
    - go to ITER, or directly to DONE with o_err=1 for mode -2.
  - ITER: one micro-rotation per cycle for ITERS cycles, then go to DONE.
  - DONE: o_valid=1; outputs stay stable until i_ready. On i_valid... handshake o_valid&&i_ready, go to IDLE. No input is accepted in DONE (o_ready=0).
- Iteration count and latency:
  - ITERS = N_ITERATION, plus in hyperbolic mode one repeat each for k=4,13,40 when k<=N_ITERATION.
  - Latency: o_valid is high in cycle t+ITERS+1, where t is the accept cycle. Default is 17 for circular/linear and 19 for hyperbolic.
  - Throughput: one result per ITERS+2 cycles when i_ready is held high.
- Direction d:
  - rotation: d=-1 if z<0, else +1;
  - vectoring: d=-1 if y>=0, else +1.
- Micro-rotation at shift s:
  - circular: x-=d*(y>>>s); y+=d*(x>>>s); z-=d*atan(2^-s); s=0..N-1.
  - linear: x unchanged; y+=d*(x>>>s); z-=d*2^-s; s=0..N-1.
  - hyperbolic: x+=d*(y>>>s); y+=d*(x>>>s); z-=d*atanh(2^-s); s=1..N with repeats.
- Initial values:
  - circular rotation: x=An=0.607253, y=0.
    - If z>pi/2: z-=pi, x=-An.
    - If z<-pi/2: z+=pi, x=-An.
  - circular vectoring: x,y taken from inputs, z=0.
    - If x<0: x=-x, y=-y, z=+pi (y>=0) or -pi (y<0).
  - hyperbolic rotation: x=1/Kh=1.207497, y=0, z=i_z.
  - hyperbolic vectoring: x,y,z=i_x,i_y,0.
  - linear rotation: x=i_x, y=0, z=i_z.
  - linear vectoring: x=i_x, y=i_y, z=0.
- Results:
  - circular rotation: o_x=cos z, o_y=sin z.
  - circular vectoring: o_x=1.646760·r, o_z=atan2(y,x).
  - linear: y=x·z (|z|<2), z=y/x (|y/x|<2).
  - hyperbolic rotation: cosh/sinh for |z|<=1.118.
  - hyperbolic vectoring: o_x=0.828159·sqrt(x²-y²), o_z=atanh(y/x).
- Arithmetic: two's complement wrap, no saturation. Out-of-range inputs give undefined values but a correct handshake.
- Constants are rounded to nearest at FRACTIONAL_BITS.

Decomposition:
- Package cordic_pkg holds:
  - mode constants;
  - constant functions building the atan/atanh tables (no .mem files), An, 1/Kh, pi and pi/2 in fixed point;
  - a function returning ITERS and the hyperbolic repeat schedule.
- Sub-module cordic_microrotation: combinational single step (x,y,z,mode,d,shift,table value in; x',y',z' out).

Test Plan:
- Circular rotation, z=0.523599 (pi/6) -> o_x=0.866025, o_y=0.5 within 2^-14; o_valid at t+17.
- Circular rotation, z=2.5 (quadrant path) -> o_x=-0.801144, o_y=0.598472 ±2^-14.
- Circular vectoring, x=-1.0, y=1.0 -> o_z=2.356194, o_x=2.328865 ±2^-13.
- Hyperbolic rotation, z=0.5 -> o_x=1.127626, o_y=0.521095 ±2^-13; o_valid at t+19.
- Linear rotation, x=1.5, z=-0.75 -> o_y=-1.125 ±2^-14, with tag 0xA returned as o_tag=0xA. Then hold i_ready=0 for 5 cycles -> outputs stable, o_ready=0.
- Mode -2 -> o_err=1 and zeros at t+1. Then i_rst_n=0 mid-ITER -> next cycle o_valid=0, o_ready=0; after release the next request completes normally.
